// File: rtl/data_access_unit.sv
// data_access_unit: memory-stage load/store sequencer.
// Accepts a load or store from the pipeline and runs one req/ack data-bus
// transaction, holding the pipeline until it finishes. Misaligned word
// accesses and bus timeouts end in a one-cycle fault pulse. Loads return
// either a sign-extended byte (lb) or a full word (lw).
module data_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       cap_we;
  logic       cap_byte;
  logic [1:0] cap_lane;

  logic       req_any;
  logic       byte_nxt;
  logic       misalign;

  // Picks the addressed byte lane and sign-extends it to a full word.
  function automatic logic [31:0] sext_byte(input logic [31:0] w, input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    r = 32'(b);
    return r;
  endfunction

  // Store takes priority, so the byte flag follows whichever access wins.
  assign req_any  = read_mem | write_mem;
  assign byte_nxt = write_mem ? store_byte : load_byte;
  assign misalign = !byte_nxt && (addr[1:0] != 2'b00);

  // Freeze upstream while a new request waits in IDLE or the bus is busy.
  assign stall = ((state == IDLE) && req_any) || (state == REQ);

  // Sequencer: capture request, drive registered bus signals, finish access.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cap_we     <= 1'b0;
      cap_byte   <= 1'b0;
      cap_lane   <= 2'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_sel    <= 4'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            cap_we   <= write_mem;
            cap_byte <= byte_nxt;
            cap_lane <= addr[1:0];
            cnt      <= 8'd0;
            if (misalign) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              bus_req  <= 1'b1;
              bus_we   <= write_mem;
              bus_addr <= {addr[31:2], 2'b00};
              if (byte_nxt) begin
                bus_sel   <= 4'b0001 << addr[1:0];
                bus_wdata <= {4{store_data[7:0]}};
              end else begin
                bus_sel   <= 4'b1111;
                bus_wdata <= store_data;
              end
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!cap_we) begin
              load_data  <= cap_byte ? sext_byte(bus_rdata, cap_lane) : bus_rdata;
              load_valid <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            fault   <= 1'b1;
            if (!cap_we) begin
              load_data <= 32'd0;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_access_unit.sv
// Testbench for data_access_unit: directed loads/stores against a simple
// bus responder, with expected bus transactions and load/fault events
// queued by the stimulus and checked by independent monitors.
module tb_data_access_unit;

  logic        clk = 1'b0;
  logic        nRst;
  logic        read_mem, write_mem, load_byte, store_byte;
  logic [31:0] addr, store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  data_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nRst(nRst),
    .read_mem(read_mem), .write_mem(write_mem),
    .load_byte(load_byte), .store_byte(store_byte),
    .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    logic        is_fault;
    logic [31:0] data;
  } ev_t;

  bus_t bus_q[$];
  ev_t  ev_q[$];

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  logic [31:0] rdata_cfg = 32'd0;
  logic        stray = 1'b0;
  int          req_cnt = 0;
  logic        prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] sel, input logic we, input logic [31:0] wd);
    bus_t t;
    t.a = a; t.sel = sel; t.we = we; t.wd = wd;
    bus_q.push_back(t);
  endtask

  task automatic exp_ev(input logic is_fault, input logic [31:0] data);
    ev_t e;
    e.is_fault = is_fault; e.data = data;
    ev_q.push_back(e);
  endtask

  // Bus responder: acks on the ack_delay-th REQ cycle (0 = never).
  always @(negedge clk) begin
    if (bus_req) begin
      req_cnt   = req_cnt + 1;
      bus_ack   = (ack_delay != 0) && (req_cnt == ack_delay);
      bus_rdata = rdata_cfg;
    end else begin
      req_cnt   = 0;
      bus_ack   = stray;
      bus_rdata = rdata_cfg;
    end
  end

  // Monitor: compares load/fault pulses and new bus transactions with the queues.
  always @(negedge clk) begin
    ev_t  e;
    bus_t t;
    if (load_valid || fault) begin
      if (ev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event load_valid=%b fault=%b load_data=%h expected no event", load_valid, fault, load_data);
      end else begin
        e = ev_q.pop_front();
        chk("event_fault", 32'(fault), 32'(e.is_fault));
        chk("event_load_valid", 32'(load_valid), 32'(!e.is_fault));
        chk("event_load_data", load_data, e.data);
      end
    end
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_bus_req addr=%h expected no request", bus_addr);
      end else begin
        t = bus_q.pop_front();
        chk("bus_addr", bus_addr, t.a);
        chk("bus_sel", 32'(bus_sel), 32'(t.sel));
        chk("bus_we", 32'(bus_we), 32'(t.we));
        chk("bus_wdata", bus_wdata, t.wd);
      end
    end
    prev_req = bus_req;
  end

  task automatic access(input string nm, input logic rd, input logic wr, input logic lb, input logic sb,
                        input logic [31:0] a, input logic [31:0] sd, input int exp_stall, input int exp_req);
    int nst;
    int nreq;
    bit done;
    nst = 0; nreq = 0; done = 1'b0;
    @(posedge clk); #1;
    read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb; addr = a; store_data = sd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus_req) nreq++;
      if (stall) nst++;
      else done = 1'b1;
    end
    read_mem = 1'b0; write_mem = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
    chk({nm, "_completed"}, 32'(done), 32'd1);
    chk({nm, "_stall_cycles"}, 32'(nst), 32'(exp_stall));
    chk({nm, "_req_cycles"}, 32'(nreq), 32'(exp_req));
    @(posedge clk);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({nm, "_bus_we"}, 32'(bus_we), 32'd0);
    chk({nm, "_bus_addr"}, bus_addr, 32'd0);
    chk({nm, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({nm, "_bus_sel"}, 32'(bus_sel), 32'd0);
    chk({nm, "_load_data"}, load_data, 32'd0);
    chk({nm, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({nm, "_fault"}, 32'(fault), 32'd0);
    chk({nm, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0;
    read_mem = 1'b0; write_mem = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
    addr = 32'd0; store_data = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;

    // lw 0x100, ack in first REQ cycle
    rdata_cfg = 32'hDEADBEEF; ack_delay = 1;
    exp_bus(32'h100, 4'b1111, 1'b0, 32'h0);
    exp_ev(1'b0, 32'hDEADBEEF);
    access("lw_100", 1, 0, 0, 0, 32'h100, 32'h0, 2, 1);

    // sb 0x203, ack after 3 REQ cycles
    ack_delay = 3;
    exp_bus(32'h200, 4'b1000, 1'b1, 32'hA5A5A5A5);
    access("sb_203", 0, 1, 0, 1, 32'h203, 32'h12345AA5, 4, 3);

    // lb lane 3, negative byte
    rdata_cfg = 32'h80112233; ack_delay = 1;
    exp_bus(32'h4, 4'b1000, 1'b0, 32'h0);
    exp_ev(1'b0, 32'hFFFFFF80);
    access("lb_7", 1, 0, 1, 0, 32'h7, 32'h0, 2, 1);

    // lb lane 2, positive byte
    exp_bus(32'h4, 4'b0100, 1'b0, 32'h0);
    exp_ev(1'b0, 32'h00000011);
    access("lb_6", 1, 0, 1, 0, 32'h6, 32'h0, 2, 1);

    // misaligned lw: fault, no bus request, load_data unchanged
    exp_ev(1'b1, 32'h00000011);
    access("lw_102", 1, 0, 0, 0, 32'h102, 32'h0, 1, 0);

    // store wins when both requests are high; byte flag follows the store
    ack_delay = 2;
    exp_bus(32'h20, 4'b0010, 1'b1, 32'h77777777);
    access("both_sb_21", 1, 1, 0, 1, 32'h21, 32'h00000077, 3, 2);

    // lw timeout: 16 REQ cycles, fault, load_data cleared
    ack_delay = 0;
    exp_bus(32'h200, 4'b1111, 1'b0, 32'h0);
    exp_ev(1'b1, 32'h0);
    access("lw_timeout", 1, 0, 0, 0, 32'h200, 32'h0, 17, 16);

    // stray ack outside REQ is ignored
    rdata_cfg = 32'hFFFFFFFF;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    chk("stray_ack_load_data", load_data, 32'h0);
    chk("stray_ack_bus_req", 32'(bus_req), 32'd0);

    // sw then lw to leave non-zero load_data before the reset test
    ack_delay = 1;
    exp_bus(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D);
    access("sw_300", 0, 1, 0, 0, 32'h300, 32'hCAFEF00D, 2, 1);
    rdata_cfg = 32'h5A5A0001;
    exp_bus(32'h104, 4'b1111, 1'b0, 32'h0);
    exp_ev(1'b0, 32'h5A5A0001);
    access("lw_104", 1, 0, 0, 0, 32'h104, 32'h0, 2, 1);

    // reset asserted in the second REQ cycle of a pending load
    ack_delay = 0;
    exp_bus(32'h400, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    read_mem = 1'b1; addr = 32'h400;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_reset_bus_req", 32'(bus_req), 32'd1);
    nRst = 1'b0; read_mem = 1'b0;
    #1;
    chk_outputs_zero("mid_req_reset");
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle_stall", 32'(stall), 32'd0);
      chk("post_reset_idle_req", 32'(bus_req), 32'd0);
    end

    // new sw completes normally
    ack_delay = 2;
    exp_bus(32'h10, 4'b1111, 1'b1, 32'h11223344);
    access("sw_after_reset", 0, 1, 0, 0, 32'h10, 32'h11223344, 3, 2);
    chk("sw_after_reset_load_data", load_data, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("event_queue_drained", 32'(ev_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
